spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  SPI-slave configuration controller for the onboarding top (tt_um_uwasic_onboarding_elvis).
//  Receives 16-bit write frames on asynchronous SCLK/COPI/nCS pins.
//  Synchronises the pins into clk and validates each frame.
//  Commits valid frames to the five 8-bit config registers that drive the output-enable
//  and PWM datapath (output enables, PWM enables, duty cycle).
//  It is the only writer of those registers.
// PARAMETERS
//  SYNC_STAGES  2    flops per pin synchroniser (>=2)
//  NUM_REGS     5    implemented registers, addresses 0..NUM_REGS-1
//  ERR_W        8    width of saturating frame-error counter
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  sclk_in          in   1  SPI clock, async, mode 0 (sample on rising)
//  copi_in          in   1  SPI data in, async, MSB first
//  ncs_in           in   1  SPI chip select, async, active low
//  en_reg_out_7_0   out  8  reg 0x00: output enables uo_out[7:0]
//  en_reg_out_15_8  out  8  reg 0x01: output enables uio_out[7:0]
//  en_reg_pwm_7_0   out  8  reg 0x02: PWM select uo_out[7:0]
//  en_reg_pwm_15_8  out  8  reg 0x03: PWM select uio_out[7:0]
//  pwm_duty_cycle   out  8  reg 0x04: PWM duty (0x00=0%, 0xFF=100%)
//  wr_strobe        out  1  1-cycle pulse on each register commit
//  wr_addr          out  7  address of last commit (valid with/after wr_strobe)
//  frame_err_cnt    out  ERR_W  count of rejected frames, saturates at all-ones
// BEHAVIOUR
//  Reset: all register outputs, wr_addr and frame_err_cnt = 0; wr_strobe = 0; FSM = IDLE.
//    Synchronisers reset to sclk=0, copi=0, ncs=1.
//  Frame format: bit15 R/W (1=write), bits14:8 addr[6:0], bits7:0 data. MSB first.
//  Sync: each pin passes SYNC_STAGES flops plus one history flop. Edges = history vs. sync value.
//  Timing: SCLK high/low phases >= SYNC_STAGES+2 clk each.
//    nCS setup/hold to SCLK >= SYNC_STAGES+2 clk.
//  FSM (all on synchronised signals):
//    IDLE  -> SHIFT on nCS falling edge; clear shift reg and 5-bit bit counter.
//    SHIFT: on SCLK rising edge with nCS low, shift in COPI.
//      Bit counter increments, saturating at 17 (detects >16 bits).
//    SHIFT -> DONE on nCS rising edge.
//    DONE  -> IDLE after one cycle; frame evaluated in DONE:
//      count!=16               -> reject, frame_err_cnt++
//      count==16, bit15=0      -> read, ignored, no error, no commit
//      count==16, addr>=NUM_REGS -> reject, frame_err_cnt++
//      otherwise               -> reg[addr]<=data, wr_strobe=1, wr_addr<=addr
//  Latency: register value and wr_strobe are visible on the clk edge ending DONE.
//    This is <= SYNC_STAGES+3 clk after the nCS pin rises.
//  Simultaneous events:
//    SCLK rising and nCS rising detected in same cycle: the SCLK edge is discarded.
//    nCS falling during DONE: the new frame is recognised; FSM enters SHIFT next cycle
//      with no lost edges.
//  Registers hold their value between commits. A rejected frame never modifies any register.
//  frame_err_cnt: never wraps. All-ones stays all-ones.
//  Async reset mid-frame: immediate return to reset state; the partial frame is lost.
// STRUCTURE
//  spi_reg_pkg: localparam ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2,
//    ADDR_EN_PWM_HI=3, ADDR_DUTY=4, FRAME_BITS=16.
//  spi_reg_pkg: state enum {IDLE, SHIFT, DONE}.
//  Sub-module sync_edge (SYNC_STAGES param): synchroniser + rise/fall detect.
//    Instanced for sclk, copi (level only), ncs.
//  Top: FSM, shift reg, bit counter, register file, error counter.
// TESTING
//  1 Reset, SPI idle (ncs=1): all regs, wr_addr, frame_err_cnt = 0; wr_strobe never pulses.
//  2 Frame 0x80F0 -> en_reg_out_7_0=0xF0; one wr_strobe pulse with wr_addr=0x00;
//    other regs unchanged.
//  3 Frames 0x8280 then 0x8401 -> en_reg_pwm_7_0=0x80, pwm_duty_cycle=0x01;
//    exactly two strobes.
//  4 Read 0x0055, then bad addr 0x85AA -> no reg change, no strobe; frame_err_cnt 0->1.
//  5 nCS high after 10 bits, then 17-bit frame -> no reg change; frame_err_cnt +2.
//    Next valid 0x81FF writes en_reg_out_15_8=0xFF.
//  6 Assert rst_n=0 mid-frame after 8 bits -> all outputs 0 immediately.
//    After release, valid 0x8433 -> pwm_duty_cycle=0x33.
//    Also: 256 bad frames hold frame_err_cnt at 0xFF.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register controller.
package spi_reg_pkg;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;
    localparam int FRAME_BITS     = 16;

    // One past a full frame, so over-long frames stay distinguishable.
    localparam int CNT_SAT = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop pin synchroniser with a history flop for rise/fall detection.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-slave write-frame receiver that commits validated frames to the
// onboarding config registers and counts rejected frames.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_in,
    input  logic             copi_in,
    input  logic             ncs_in,
    output logic [7:0]       en_reg_out_7_0,
    output logic [7:0]       en_reg_out_15_8,
    output logic [7:0]       en_reg_pwm_7_0,
    output logic [7:0]       en_reg_pwm_15_8,
    output logic [7:0]       pwm_duty_cycle,
    output logic             wr_strobe,
    output logic [6:0]       wr_addr,
    output logic [ERR_W-1:0] frame_err_cnt
);

    localparam logic [6:0] NUM_REGS_W  = 7'(NUM_REGS);
    localparam logic [4:0] CNT_FULL    = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT_W   = 5'(CNT_SAT);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic copi_level, copi_rise_unused, copi_fall_unused;
    logic ncs_level, ncs_rise, ncs_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk_in),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi_in),
        .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs_in),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_t            state, next_state;
    logic [15:0]       shift_q;
    logic [4:0]        bit_cnt;
    logic [7:0]        regs [NUM_REGS];
    logic              clear, shift_en, commit, reject;
    logic [6:0]        frame_addr;
    logic [7:0]        frame_data;

    assign frame_addr = shift_q[14:8];
    assign frame_data = shift_q[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A new frame may start in DONE; clearing there keeps back-to-back frames lossless.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        shift_en   = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    next_state = SHIFT;
                    clear      = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise)                     next_state = DONE;
                else if (sclk_rise && !ncs_level) shift_en   = 1'b1;
            end
            DONE: begin
                if (bit_cnt != CNT_FULL)          reject = 1'b1;
                else if (shift_q[15]) begin
                    if (frame_addr < NUM_REGS_W)  commit = 1'b1;
                    else                          reject = 1'b1;
                end
                next_state = IDLE;
                if (ncs_fall) begin
                    next_state = SHIFT;
                    clear      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[14:0], copi_level};
            if (bit_cnt != CNT_SAT_W) bit_cnt <= bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_strobe     <= 1'b0;
            wr_addr       <= '0;
            frame_err_cnt <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) wr_addr <= frame_addr;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && frame_addr == 7'(i)) regs[i] <= frame_data;
            end
            if (reject && frame_err_cnt != {ERR_W{1'b1}})
                frame_err_cnt <= frame_err_cnt + 1'b1;
        end
    end

    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: directed SPI frames, strobe monitor pops
// expected commits, and register/error-count snapshots use hand-computed values.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk_in = 1'b0;
    logic       copi_in = 1'b0;
    logic       ncs_in = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] frame_err_cnt;

    int tests = 0;
    int fails = 0;
    logic [14:0] exp_q [$];

    spi_reg_ctrl #(.SYNC_STAGES(2), .NUM_REGS(5), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .sclk_in(sclk_in), .copi_in(copi_in), .ncs_in(ncs_in),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input logic [6:0] a);
        case (a)
            7'd0:    return en_reg_out_7_0;
            7'd1:    return en_reg_out_15_8;
            7'd2:    return en_reg_pwm_7_0;
            7'd3:    return en_reg_pwm_15_8;
            7'd4:    return pwm_duty_cycle;
            default: return 8'hxx;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", {25'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                checkOutput("strobe_addr", {25'd0, wr_addr}, {25'd0, e[14:8]});
                checkOutput("strobe_data", {24'd0, reg_at(wr_addr)}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic shiftBits(input logic [31:0] frame, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi_in = frame[i];
            wait_clk(8);
            sclk_in = 1'b1;
            wait_clk(8);
            sclk_in = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] frame, input int nbits, input logic expect_commit);
        if (expect_commit) exp_q.push_back({frame[14:8], frame[7:0]});
        ncs_in = 1'b0;
        wait_clk(8);
        shiftBits(frame, nbits);
        wait_clk(8);
        ncs_in = 1'b1;
        wait_clk(20);
    endtask

    task automatic badFrame();
        ncs_in = 1'b0;
        wait_clk(6);
        ncs_in = 1'b1;
        wait_clk(8);
    endtask

    task automatic checkRegs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                             input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4,
                             input logic [7:0] err);
        @(negedge clk);
        checkOutput({tag, "_reg0"}, {24'd0, en_reg_out_7_0},  {24'd0, r0});
        checkOutput({tag, "_reg1"}, {24'd0, en_reg_out_15_8}, {24'd0, r1});
        checkOutput({tag, "_reg2"}, {24'd0, en_reg_pwm_7_0},  {24'd0, r2});
        checkOutput({tag, "_reg3"}, {24'd0, en_reg_pwm_15_8}, {24'd0, r3});
        checkOutput({tag, "_reg4"}, {24'd0, pwm_duty_cycle},  {24'd0, r4});
        checkOutput({tag, "_err"},  {24'd0, frame_err_cnt},   {24'd0, err});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wait_clk(3);
        #2 rst_n = 1'b1;
        wait_clk(20);
        checkRegs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("reset_wr_addr", {25'd0, wr_addr}, 32'd0);

        applyStimulus(32'h80F0, 16, 1'b1);
        checkRegs("wr_f0", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        applyStimulus(32'h8280, 16, 1'b1);
        applyStimulus(32'h8401, 16, 1'b1);
        checkRegs("two_wr", 8'hF0, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00);

        applyStimulus(32'h0055, 16, 1'b0);
        checkRegs("read", 8'hF0, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00);
        applyStimulus(32'h85AA, 16, 1'b0);
        checkRegs("bad_addr", 8'hF0, 8'h00, 8'h80, 8'h00, 8'h01, 8'h01);

        applyStimulus(32'h0203, 10, 1'b0);
        applyStimulus(32'h1_80AA, 17, 1'b0);
        checkRegs("bad_len", 8'hF0, 8'h00, 8'h80, 8'h00, 8'h01, 8'h03);
        applyStimulus(32'h81FF, 16, 1'b1);
        checkRegs("wr_ff", 8'hF0, 8'hFF, 8'h80, 8'h00, 8'h01, 8'h03);

        ncs_in = 1'b0;
        wait_clk(8);
        shiftBits(32'h0084, 8);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_reg0", {24'd0, en_reg_out_7_0},  32'd0);
        checkOutput("midrst_reg1", {24'd0, en_reg_out_15_8}, 32'd0);
        checkOutput("midrst_reg2", {24'd0, en_reg_pwm_7_0},  32'd0);
        checkOutput("midrst_reg4", {24'd0, pwm_duty_cycle},  32'd0);
        checkOutput("midrst_err",  {24'd0, frame_err_cnt},   32'd0);
        checkOutput("midrst_strobe", {31'd0, wr_strobe},     32'd0);
        ncs_in = 1'b1;
        wait_clk(5);
        #2 rst_n = 1'b1;
        wait_clk(10);

        applyStimulus(32'h8433, 16, 1'b1);
        checkRegs("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00);

        for (int i = 0; i < 254; i++) badFrame();
        checkRegs("err_254", 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'hFE);
        badFrame();
        checkRegs("err_255", 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'hFF);
        badFrame();
        badFrame();
        checkRegs("err_sat", 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'hFF);

        wait_clk(20);
        checkOutput("pending_strobes", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
